// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN to add an even-parity bit.
// Mid-bit sampling of a 2-flop synchronized line; registered valid/error pulses.
module uart_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF_INT     = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0;
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_INT);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;
`endif

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             cnt_zero;
  logic             frame_ok;
`ifdef UART_RX_PARITY_EN
  logic             par_ok_q, par_ok_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= par_ok_d;
`endif
    end
  end

  assign cnt_zero = (cnt_q == '0);

  // A frame is accepted only with a high stop bit (and matching parity when present).
`ifdef UART_RX_PARITY_EN
  assign frame_ok = rx_s_q & par_ok_q;
`else
  assign frame_ok = rx_s_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d = par_ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
          idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_LOAD;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          par_ok_d = ((^shift_q) == rx_s_q);
          cnt_d    = FULL_LOAD;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (frame_ok) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          // A low stop bit is a break/framing error: wait for the line to return high.
          err_d   = 1'b1;
          state_d = rx_s_q ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes against a
// frame-level reference model (expected byte / pulse counts per frame).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_NS = 8680;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NRAND  = 1;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NRAND  = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int         checkCount = 0;
  int         passCount  = 0;
  int         validCount = 0;
  int         errCount   = 0;
  int         overlapCount = 0;
  logic [7:0] lastData = 8'h00;

  uart_rx #(.CLK_FREQ(100000000), .BAUD(115200)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) validCount++;
    if (frame_err) errCount++;
    if (rx_valid && frame_err) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badPar);
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      #(BIT_NS);
    end
    if (PAR_EN) begin
      rx = (^data) ^ badPar;
      #(BIT_NS);
    end
    rx = stopBit;
    #(BIT_NS);
  endtask

  task automatic sendFrame(input string tag, input logic [7:0] data, input logic stopBit,
                           input logic badPar);
    int  v0 = validCount;
    int  e0 = errCount;
    bit  good = stopBit && !(PAR_EN && badPar);
    applyStimulus(data, stopBit, badPar);
    if (good) lastData = data;
    checkOutput({tag, "_valid"}, 32'(validCount - v0), good ? 32'd1 : 32'd0);
    checkOutput({tag, "_err"},   32'(errCount - e0),   good ? 32'd0 : 32'd1);
    checkOutput({tag, "_data"},  32'(rx_data), 32'(lastData));
  endtask

  initial begin
    int         v0;
    int         e0;
    logic [7:0] rdata;
    logic       rstop;
    logic       rbad;

    rst = 1'b0;
    rx  = 1'b1;
    #20;
    checkOutput("rst_data",  32'(rx_data),   32'h00);
    checkOutput("rst_valid", 32'(rx_valid),  32'h0);
    checkOutput("rst_busy",  32'(rx_busy),   32'h0);
    checkOutput("rst_err",   32'(frame_err), 32'h0);
    rst = 1'b1;
    #100000;
    checkOutput("idle_valid", 32'(validCount), 32'd0);
    checkOutput("idle_err",   32'(errCount),   32'd0);

    sendFrame("R", 8'h52, 1'b1, 1'b0);
    #200;
    sendFrame("b2b_H", 8'h48, 1'b1, 1'b0);
    sendFrame("b2b_R", 8'h52, 1'b1, 1'b0);
    #200;

    v0 = validCount;
    e0 = errCount;
    rx = 1'b0;
    #1000;
    checkOutput("glitch_busy_hi", 32'(rx_busy), 32'h1);
    #1000;
    rx = 1'b1;
    #4340;
    checkOutput("glitch_busy_lo", 32'(rx_busy), 32'h0);
    checkOutput("glitch_valid", 32'(validCount - v0), 32'd0);
    checkOutput("glitch_err",   32'(errCount - e0),   32'd0);
    #200;

    e0 = errCount;
    sendFrame("brk", 8'hA5, 1'b0, 1'b0);
    #50000;
    checkOutput("brk_busy_hi", 32'(rx_busy), 32'h1);
    checkOutput("brk_one_err", 32'(errCount - e0), 32'd1);
    rx = 1'b1;
    #100;
    checkOutput("brk_busy_lo", 32'(rx_busy), 32'h0);
    checkOutput("brk_data", 32'(rx_data), 32'(lastData));
    #200;

`ifdef UART_RX_PARITY_EN
    sendFrame("par_bad", 8'h52, 1'b1, 1'b1);
    #200;
    sendFrame("par_ok", 8'h52, 1'b1, 1'b0);
    #200;
`endif

    for (int i = 0; i < NRAND; i++) begin
      rdata = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rbad  = PAR_EN && ($urandom_range(0, 2) == 0);
      sendFrame("rnd", rdata, rstop, rbad);
      rx = 1'b1;
      #(10 * $urandom_range(5, 60));
    end

    checkOutput("overlap", 32'(overlapCount), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
